// File: rtl/iter_cla_seq_pkg.sv
// Shared definitions for the iterative carry-lookahead adder.
// Holds the slice width, the controller state encoding and the
// index-width helper used to size the slice counter.
package iter_cla_seq_pkg;

  // Width of the single reused carry-lookahead slice.
  localparam int unsigned SLICE_W = 4;

  // Controller states: waiting for operands, stepping slices, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1 so the slice index is never zero-width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/iter_cla_seq_cla4_slice.sv
// 4-bit carry-lookahead slice reused each cycle by iter_cla_seq.
// Carries are formed directly from per-bit generate/propagate terms
// rather than rippled; the carry into bit 3 is exported so the parent
// can derive two's-complement overflow on the most significant slice.
module cla4_slice (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  output logic [3:0] s4,
  output logic       cout,
  output logic       c3
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  // Per-bit propagate/generate and fully expanded lookahead carries.
  always_comb begin
    p    = a4 ^ b4;
    g    = a4 & b4;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s4   = p ^ c;
    c3   = c[3];
  end

endmodule

// File: rtl/iter_cla_seq.sv
// Iterative WIDTH-bit adder: one 4-bit carry-lookahead slice is stepped
// over WIDTH/4 cycles, least significant nibble first, behind a
// valid/ready handshake on both sides.
// Optional feature: define ITER_CLA_SUB_EN to make op = 1 compute a - b
// (b inverted at load, initial carry 1); otherwise op is ignored.
module iter_cla_seq
  import iter_cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / SLICE_W;
  localparam int unsigned IDX_W = clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   sum_d;
  logic               c_out_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   b_load;
  logic               cin_load;
  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  logic [SLICE_W-1:0] s_nib;
  logic               slice_cout;
  logic               slice_c3;

`ifdef ITER_CLA_SUB_EN
  // Subtract is folded into the load: a + ~b + 1.
  always_comb begin
    b_load   = b;
    cin_load = 1'b0;
    if (op) begin
      b_load   = ~b;
      cin_load = 1'b1;
    end
  end
`else
  logic unused_op;
  assign unused_op = op;

  // Add-only build: operand B passes through, initial carry is zero.
  always_comb begin
    b_load   = b;
    cin_load = 1'b0;
  end
`endif

  // Select the operand nibbles addressed by the slice index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_nib = a_q[k*SLICE_W +: SLICE_W];
        b_nib = b_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  cla4_slice u_slice (
    .a4   (a_nib),
    .b4   (b_nib),
    .cin  (carry_q),
    .s4   (s_nib),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // Merge the current slice sum into its nibble of the result.
  always_comb begin
    sum_d = sum_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sum_d[k*SLICE_W +: SLICE_W] = s_nib;
      end
    end
  end

  // Controller and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b_load;
            carry_q    <= cin_load;
            idx_q      <= '0;
            sum_q      <= '0;
            c_out_q    <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            // Carry into bit 3 of the top slice is the carry into the MSB.
            c_out_q     <= slice_cout;
            ovf_q       <= slice_c3 ^ slice_cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/iter_cla_seq.md
ITER_CLA_SEQ -- requirements
Module: iter_cla_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, meaning operand width, a multiple of 4 and at least 8.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset: one clock, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  operand request.
REQ-005 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-006 The block SHALL have port a  input  WIDTH  operand A.
REQ-007 The block SHALL have port b  input  WIDTH  operand B.
REQ-008 The block SHALL have port op  input  1  0 = add, 1 = subtract (see REQ-027).
REQ-009 The block SHALL have port out_valid  output  1  result available.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port sum  output  WIDTH  result.
REQ-012 The block SHALL have port c_out  output  1  carry out of the MSB slice.
REQ-013 The block SHALL have port ovf  output  1  two's-complement overflow.

Function
REQ-014 The block SHALL compute a WIDTH-bit add by reusing one 4-bit carry-lookahead slice over N = WIDTH/4 cycles, least significant nibble first.
REQ-015 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 On in_valid && in_ready, the block SHALL latch a and b (and op), set the carry register to the initial carry-in, clear the slice index, and go to RUN.
REQ-018 In RUN, each cycle SHALL process slice k: write sum[4k+3:4k] and update the carry register with the slice carry-out.
REQ-019 After slice N-1 the FSM SHALL go to DONE; out_valid SHALL be 1 exactly N cycles after the accepting edge.
REQ-020 out_valid SHALL be 1 only in DONE.
REQ-021 sum, c_out and ovf SHALL stay stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready the FSM SHALL return to IDLE; the next accept occurs no earlier than the following cycle.
REQ-023 ovf SHALL equal (carry into bit WIDTH-1) XOR c_out.
REQ-024 Inputs a, b and op SHALL be ignored outside an accepting handshake.

Reset
REQ-025 While rst_n = 0, the block SHALL force FSM = IDLE, in_ready = 1 (after the reset edge), out_valid = 0, sum = 0, c_out = 0, ovf = 0, and clear the index and carry registers.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result emitted; operation resumes from IDLE after reset deassertion.

Configuration
REQ-027 With macro ITER_CLA_SUB_EN defined, op = 1 SHALL latch ~b with initial carry 1, giving a - b (c_out = 1 means no borrow).
REQ-028 Without ITER_CLA_SUB_EN, op SHALL be ignored and the block SHALL always add with initial carry 0.

Structure
REQ-029 The shared package SHALL hold the SLICE_W = 4 constant, the FSM state enum, and the index-width function clog2(WIDTH/4).
REQ-030 The 4-bit slice SHALL be a sub-module cla4_slice: inputs a4, b4, cin; outputs s4, cout, and the carry into bit 3; internal per-bit P/G lookahead.

Verification
REQ-031 The bench SHALL check a = 0xFFFFFFFF, b = 0x00000001, op = 0 -> sum = 0x00000000, c_out = 1, ovf = 0, out_valid 8 cycles after accept.
REQ-032 The bench SHALL check a = 0x7FFFFFFF, b = 0x00000001 -> sum = 0x80000000, c_out = 0, ovf = 1.
REQ-033 The bench SHALL check, with ITER_CLA_SUB_EN, a = 5, b = 7, op = 1 -> sum = 0xFFFFFFFE, c_out = 0, ovf = 0; without the macro, same stimulus -> sum = 0x0000000C.
REQ-034 The bench SHALL check out_ready held 0 for 5 cycles in DONE -> out_valid and sum stable and in_ready = 0 throughout; release -> IDLE next cycle.
REQ-035 The bench SHALL check rst_n pulsed low at RUN slice 3 -> out_valid = 0, sum = 0 immediately; a new request then completes correctly in 8 cycles.
REQ-036 The bench SHALL check back-to-back requests with in_valid held high and out_ready = 1 -> each result matches, with exactly one idle-accept cycle between operations.
